// File: rtl/cci_mpf_shim_pwrite_pkg.sv
// Shared types and width helpers for the partial-write lock tracker.
// Index typedefs are declared inside each parameterized module.
package cci_mpf_shim_pwrite_pkg;

  // Widest flattened index bus that slice_idx() can accept.
  localparam int unsigned FlatMaxW = 1024;

  typedef enum logic [1:0] {
    ErrNone,
    ErrOverflow,
    ErrUnderflow
  } t_pwrite_lock_err;

  function automatic int unsigned idx_width(int unsigned n_entries);
    return $clog2(n_entries);
  endfunction

  function automatic int unsigned cnt_width(int unsigned max_locks);
    return $clog2(max_locks + 1);
  endfunction

  // Signed width for cnt + L - U, with headroom for both clamp directions.
  function automatic int unsigned sum_width(int unsigned cnt_w, int unsigned n_chan);
    return cnt_w + $clog2(n_chan) + 2;
  endfunction

  function automatic int unsigned slice_idx(logic [FlatMaxW-1:0] flat, int unsigned idx_w,
                                            int unsigned chan);
    return 32'(flat >> (chan * idx_w)) & ((32'd1 << idx_w) - 32'd1);
  endfunction

endpackage

// File: rtl/cci_mpf_shim_pwrite_lock_cnt.sv
// One saturating up/down lock counter. Errors are reported as per-cycle pulses;
// the owner of the counter decides whether they are sticky.
module cci_mpf_shim_pwrite_lock_cnt
  import cci_mpf_shim_pwrite_pkg::*;
#(
  parameter int unsigned MAX_LOCKS = 3,
  parameter int unsigned N_CHAN    = 2,
  localparam int unsigned CntW = cnt_width(MAX_LOCKS),
  localparam int unsigned IncW = $clog2(N_CHAN + 1),
  localparam int unsigned SumW = sum_width(CntW, N_CHAN)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [IncW-1:0] n_inc,
  input  logic [IncW-1:0] n_dec,
  output logic [CntW-1:0] count,
  output logic            nonzero_next,
  output logic            ovf,
  output logic            udf
);

  logic [CntW-1:0]        r_cnt;
  logic [CntW-1:0]        w_cnt_d;
  logic signed [SumW-1:0] w_sum;
  t_pwrite_lock_err       w_err;

  always_comb begin
    w_sum   = $signed(SumW'(r_cnt)) + $signed(SumW'(n_inc)) - $signed(SumW'(n_dec));
    w_err   = ErrNone;
    w_cnt_d = CntW'(w_sum);
    if (reset) begin
      w_cnt_d = '0;
    end else if (w_sum[SumW-1]) begin
      w_cnt_d = '0;
      w_err   = ErrUnderflow;
    end else if (w_sum > $signed(SumW'(MAX_LOCKS))) begin
      w_cnt_d = CntW'(MAX_LOCKS);
      w_err   = ErrOverflow;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_d;
    end
  end

  assign count        = r_cnt;
  assign nonzero_next = (w_cnt_d != '0);
  assign ovf          = (w_err == ErrOverflow);
  assign udf          = (w_err == ErrUnderflow);

endmodule

// File: rtl/cci_mpf_shim_pwrite_lock_tracker.sv
// Counting lock tracker for write heap indices awaiting FIU-edge data.
// Queries see same-cycle lock/unlock updates (forwarded via nonzero_next).
module cci_mpf_shim_pwrite_lock_tracker
  import cci_mpf_shim_pwrite_pkg::*;
#(
  parameter int unsigned N_WRITE_HEAP_ENTRIES = 128,
  parameter int unsigned N_LOCK_CHANNELS      = 2,
  parameter int unsigned N_QUERY_PORTS        = 2,
  parameter int unsigned MAX_LOCKS_PER_IDX    = 3,
  localparam int unsigned IdxW  = idx_width(N_WRITE_HEAP_ENTRIES),
  localparam int unsigned CntW  = cnt_width(MAX_LOCKS_PER_IDX),
  localparam int unsigned IncW  = $clog2(N_LOCK_CHANNELS + 1),
  localparam int unsigned NLckW = IdxW + 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [N_LOCK_CHANNELS-1:0]      lock_idx_en,
  input  logic [N_LOCK_CHANNELS*IdxW-1:0] lock_idx,
  input  logic [N_LOCK_CHANNELS-1:0]      unlock_idx_en,
  input  logic [N_LOCK_CHANNELS*IdxW-1:0] unlock_idx,
  input  logic [N_QUERY_PORTS-1:0]        query_en,
  input  logic [N_QUERY_PORTS*IdxW-1:0]   query_idx,
  output logic [N_QUERY_PORTS-1:0]        query_valid,
  output logic [N_QUERY_PORTS-1:0]        query_locked,
  output logic [NLckW-1:0]                n_locked,
  output logic                            idle,
  output logic                            err_overflow,
  output logic                            err_underflow
);

  typedef logic [IdxW-1:0] t_heap_idx;

  logic [FlatMaxW-1:0] w_lock_flat, w_unlock_flat, w_query_flat;
  t_heap_idx           w_lock_idx   [N_LOCK_CHANNELS];
  t_heap_idx           w_unlock_idx [N_LOCK_CHANNELS];
  t_heap_idx           w_query_idx  [N_QUERY_PORTS];

  logic [IncW-1:0] w_n_inc [N_WRITE_HEAP_ENTRIES];
  logic [IncW-1:0] w_n_dec [N_WRITE_HEAP_ENTRIES];
  logic [CntW-1:0] w_cnt   [N_WRITE_HEAP_ENTRIES];

  logic [N_WRITE_HEAP_ENTRIES-1:0] w_nz_next, w_ovf, w_udf;
  logic [N_QUERY_PORTS-1:0]        w_query_locked_d;
  logic [NLckW-1:0]                w_n_locked_d;

  logic [N_QUERY_PORTS-1:0] r_query_valid, r_query_locked;
  logic [NLckW-1:0]         r_n_locked;
  logic                     r_idle, r_err_ovf, r_err_udf;

  assign w_lock_flat   = FlatMaxW'(lock_idx);
  assign w_unlock_flat = FlatMaxW'(unlock_idx);
  assign w_query_flat  = FlatMaxW'(query_idx);

  always_comb begin
    for (int c = 0; c < N_LOCK_CHANNELS; c++) begin
      w_lock_idx[c]   = IdxW'(slice_idx(w_lock_flat, IdxW, c));
      w_unlock_idx[c] = IdxW'(slice_idx(w_unlock_flat, IdxW, c));
    end
    for (int q = 0; q < N_QUERY_PORTS; q++) begin
      w_query_idx[q] = IdxW'(slice_idx(w_query_flat, IdxW, q));
    end
  end

  // Count how many channels hit each index this cycle.
  always_comb begin
    for (int i = 0; i < N_WRITE_HEAP_ENTRIES; i++) begin
      w_n_inc[i] = '0;
      w_n_dec[i] = '0;
      for (int c = 0; c < N_LOCK_CHANNELS; c++) begin
        if (lock_idx_en[c] && (w_lock_idx[c] == IdxW'(i))) begin
          w_n_inc[i] = w_n_inc[i] + IncW'(1);
        end
        if (unlock_idx_en[c] && (w_unlock_idx[c] == IdxW'(i))) begin
          w_n_dec[i] = w_n_dec[i] + IncW'(1);
        end
      end
    end
  end

  for (genvar gi = 0; gi < N_WRITE_HEAP_ENTRIES; gi++) begin : g_cnt
    cci_mpf_shim_pwrite_lock_cnt #(
      .MAX_LOCKS (MAX_LOCKS_PER_IDX),
      .N_CHAN    (N_LOCK_CHANNELS)
    ) u_cnt (
      .clk          (clk),
      .reset        (reset),
      .n_inc        (w_n_inc[gi]),
      .n_dec        (w_n_dec[gi]),
      .count        (w_cnt[gi]),
      .nonzero_next (w_nz_next[gi]),
      .ovf          (w_ovf[gi]),
      .udf          (w_udf[gi])
    );

    a_cnt_max : assert property (@(posedge clk) w_cnt[gi] <= CntW'(MAX_LOCKS_PER_IDX));
  end

  always_comb begin
    w_n_locked_d = '0;
    for (int i = 0; i < N_WRITE_HEAP_ENTRIES; i++) begin
      w_n_locked_d = w_n_locked_d + NLckW'(w_nz_next[i]);
    end
    for (int q = 0; q < N_QUERY_PORTS; q++) begin
      w_query_locked_d[q] = query_en[q] & w_nz_next[w_query_idx[q]];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_query_valid  <= '0;
      r_query_locked <= '0;
      r_n_locked     <= '0;
      r_idle         <= 1'b1;
      r_err_ovf      <= 1'b0;
      r_err_udf      <= 1'b0;
    end else begin
      r_query_valid  <= query_en;
      r_query_locked <= w_query_locked_d;
      r_n_locked     <= w_n_locked_d;
      r_idle         <= (w_n_locked_d == '0);
      r_err_ovf      <= r_err_ovf | (|w_ovf);
      r_err_udf      <= r_err_udf | (|w_udf);
    end
  end

  assign query_valid   = r_query_valid;
  assign query_locked  = r_query_locked;
  assign n_locked      = r_n_locked;
  assign idle          = r_idle;
  assign err_overflow  = r_err_ovf;
  assign err_underflow = r_err_udf;

endmodule

// File: tb/tb_cci_mpf_shim_pwrite_lock_tracker.sv
// Bench for the lock tracker: directed vector table, then random traffic
// checked against a per-index counting model.
module tb_cci_mpf_shim_pwrite_lock_tracker;

  localparam int NE   = 128;
  localparam int IW   = 7;
  localparam int MAXL = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    lock_idx_en, unlock_idx_en, query_en;
  logic [2*IW-1:0] lock_idx, unlock_idx, query_idx;
  logic [1:0]    query_valid, query_locked;
  logic [IW:0]   n_locked;
  logic          idle, err_overflow, err_underflow;

  always #5 clk = ~clk;

  cci_mpf_shim_pwrite_lock_tracker dut (
    .clk           (clk),
    .reset         (reset),
    .lock_idx_en   (lock_idx_en),
    .lock_idx      (lock_idx),
    .unlock_idx_en (unlock_idx_en),
    .unlock_idx    (unlock_idx),
    .query_en      (query_en),
    .query_idx     (query_idx),
    .query_valid   (query_valid),
    .query_locked  (query_locked),
    .n_locked      (n_locked),
    .idle          (idle),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state: plain per-index lock counts.
  int m_cnt [NE];
  int m_ovf = 0, m_udf = 0;
  int e_qv = 0, e_ql = 0, e_n = 0;

  typedef struct {
    int rst;
    int len; int li0; int li1;
    int uen; int ui0; int ui1;
    int qen; int qi0; int qi1;
    int eqv; int eql; int en; int eovf; int eudf;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step(input int rst, input int len, input int li[2], input int uen,
                            input int ui[2], input int qen, input int qi[2]);
    int d [NE];
    if (rst != 0) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_ovf = 0; m_udf = 0; e_qv = 0; e_ql = 0; e_n = 0;
      return;
    end
    foreach (d[i]) d[i] = 0;
    for (int c = 0; c < 2; c++) begin
      if (len[c]) d[li[c]] += 1;
      if (uen[c]) d[ui[c]] -= 1;
    end
    e_n = 0;
    for (int i = 0; i < NE; i++) begin
      int nx;
      nx = m_cnt[i] + d[i];
      if (nx < 0) begin nx = 0; m_udf = 1; end
      else if (nx > MAXL) begin nx = MAXL; m_ovf = 1; end
      m_cnt[i] = nx;
      if (nx > 0) e_n++;
    end
    e_qv = qen;
    e_ql = 0;
    for (int q = 0; q < 2; q++) begin
      if (qen[q] && m_cnt[qi[q]] > 0) e_ql |= (1 << q);
    end
  endtask

  task automatic apply(input int rst, input int len, input int li0, input int li1,
                       input int uen, input int ui0, input int ui1,
                       input int qen, input int qi0, input int qi1);
    int li[2], ui[2], qi[2];
    li = '{li0, li1}; ui = '{ui0, ui1}; qi = '{qi0, qi1};
    @(negedge clk);
    reset         = rst[0];
    lock_idx_en   = 2'(len);
    lock_idx      = {7'(li1), 7'(li0)};
    unlock_idx_en = 2'(uen);
    unlock_idx    = {7'(ui1), 7'(ui0)};
    query_en      = 2'(qen);
    query_idx     = {7'(qi1), 7'(qi0)};
    model_step(rst, len, li, uen, ui, qen, qi);
    @(posedge clk);
    #1;
    chk("model_query_valid", int'(query_valid), e_qv);
    chk("model_query_locked", int'(query_locked), e_ql);
    chk("model_n_locked", int'(n_locked), e_n);
    chk("model_idle", int'(idle), int'(e_n == 0));
    chk("model_err_overflow", int'(err_overflow), m_ovf);
    chk("model_err_underflow", int'(err_underflow), m_udf);
  endtask

  initial begin
    foreach (m_cnt[i]) m_cnt[i] = 0;
    reset = 1'b1;
    lock_idx_en = '0; unlock_idx_en = '0; query_en = '0;
    lock_idx = '0; unlock_idx = '0; query_idx = '0;

    //            rst len li0 li1 uen ui0 ui1 qen qi0 qi1 eqv eql en ovf udf
    tbl.push_back('{1, 0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0, 0, 0, 0});
    tbl.push_back('{0, 0,  0,  0,  0,  0,  0,  1,  5,  0,  1,  0, 0, 0, 0});
    tbl.push_back('{0, 1,  7,  0,  0,  0,  0,  1,  7,  0,  1,  1, 1, 0, 0});
    tbl.push_back('{0, 0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0, 1, 0, 0});
    tbl.push_back('{0, 0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0, 1, 0, 0});
    tbl.push_back('{0, 0,  0,  0,  1,  7,  0,  1,  7,  0,  1,  0, 0, 0, 0});
    tbl.push_back('{0, 3,  3,  3,  0,  0,  0,  1,  3,  0,  1,  1, 1, 0, 0});
    tbl.push_back('{0, 0,  0,  0,  1,  3,  0,  2,  0,  3,  2,  2, 1, 0, 0});
    tbl.push_back('{0, 0,  0,  0,  2,  0,  3,  1,  3,  0,  1,  0, 0, 0, 0});
    tbl.push_back('{0, 3,  9,  9,  0,  0,  0,  1,  9,  0,  1,  1, 1, 0, 0});
    tbl.push_back('{0, 3,  9,  9,  0,  0,  0,  1,  9,  0,  1,  1, 1, 1, 0});
    tbl.push_back('{0, 0,  0,  0,  3,  9,  9,  1,  9,  0,  1,  1, 1, 1, 0});
    tbl.push_back('{0, 0,  0,  0,  1,  9,  0,  1,  9,  0,  1,  0, 0, 1, 0});
    tbl.push_back('{0, 0,  0,  0,  1,  9,  0,  1,  9,  0,  1,  0, 0, 1, 1});
    tbl.push_back('{1, 0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0, 0, 0, 0});
    tbl.push_back('{0, 1, 12,  0,  2,  0, 12,  3, 12, 12,  3,  0, 0, 0, 0});
    tbl.push_back('{0, 3,  0, 63,  0,  0,  0,  0,  0,  0,  0,  0, 2, 0, 0});
    tbl.push_back('{0, 1,127,  0,  2,  0,100,  3,  0, 63,  3,  3, 3, 0, 1});
    tbl.push_back('{1, 1,  1,  0,  0,  0,  0,  1,  1,  0,  0,  0, 0, 0, 0});
    tbl.push_back('{0, 0,  0,  0,  0,  0,  0,  3,  0,127,  3,  0, 0, 0, 0});
    tbl.push_back('{0, 0,  0,  0,  0,  0,  0,  3,  1, 63,  3,  0, 0, 0, 0});

    foreach (tbl[k]) begin
      vec_t v;
      v = tbl[k];
      apply(v.rst, v.len, v.li0, v.li1, v.uen, v.ui0, v.ui1, v.qen, v.qi0, v.qi1);
      chk($sformatf("vec%0d_query_valid", k), int'(query_valid), v.eqv);
      chk($sformatf("vec%0d_query_locked", k), int'(query_locked), v.eql);
      chk($sformatf("vec%0d_n_locked", k), int'(n_locked), v.en);
      chk($sformatf("vec%0d_idle", k), int'(idle), int'(v.en == 0));
      chk($sformatf("vec%0d_err_overflow", k), int'(err_overflow), v.eovf);
      chk($sformatf("vec%0d_err_underflow", k), int'(err_underflow), v.eudf);
    end

    // Random traffic on a narrow index window to force collisions and clamps.
    for (int n = 0; n < 600; n++) begin
      int base;
      base = (n < 300) ? 0 : 120;
      apply(int'($urandom_range(0, 63) == 0),
            int'($urandom_range(0, 3)), base + int'($urandom_range(0, 7)),
            base + int'($urandom_range(0, 7)),
            int'($urandom_range(0, 3)), base + int'($urandom_range(0, 7)),
            base + int'($urandom_range(0, 7)),
            int'($urandom_range(0, 3)), base + int'($urandom_range(0, 7)),
            base + int'($urandom_range(0, 7)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cci_mpf_shim_pwrite_lock_tracker.md
Name: cci_mpf_shim_pwrite_lock_tracker

Overview:
Multi-channel, counting successor to the single-port partial-write lock interface. It tracks write heap indices whose data has not yet reached the FIU-edge write data heap. It accepts N lock and N unlock events per cycle, permits multiple outstanding locks per index, and answers M independent "is index locked" queries. It sits between the pwrite edge modules (FIU and AFU) and the partial write shim, which gates write-request release on query results.

Parameters:
N_WRITE_HEAP_ENTRIES, 128, heap depth; power of 2, >=2; IDX_W = $clog2(N_WRITE_HEAP_ENTRIES)
N_LOCK_CHANNELS, 2, lock/unlock port pairs (>=1)
N_QUERY_PORTS, 2, independent lookup ports (>=1)
MAX_LOCKS_PER_IDX, 3, max outstanding locks per index; CNT_W = $clog2(MAX_LOCKS_PER_IDX+1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
lock_idx_en  in  N_LOCK_CHANNELS  per-channel lock strobe
lock_idx  in  N_LOCK_CHANNELS*IDX_W  per-channel index; channel c occupies bits [c*IDX_W +: IDX_W]
unlock_idx_en  in  N_LOCK_CHANNELS  per-channel unlock strobe
unlock_idx  in  N_LOCK_CHANNELS*IDX_W  per-channel unlock index
query_en  in  N_QUERY_PORTS  query strobe
query_idx  in  N_QUERY_PORTS*IDX_W  query index
query_valid  out  N_QUERY_PORTS  registered copy of query_en
query_locked  out  N_QUERY_PORTS  index count nonzero (see latency)
n_locked  out  IDX_W+1  number of indices with nonzero count
idle  out  1  n_locked == 0
err_overflow  out  1  sticky: a lock was lost to saturation
err_underflow  out  1  sticky: an unlock targeted a zero count

Behaviour:
- One clock (clk). Reset is synchronous and active-high.
- State: one CNT_W-bit counter per heap index, held in flops (not RAM), so reset clears every counter in one cycle.
- Reset values: all counters 0, query_valid 0, query_locked 0, n_locked 0, idle 1, err_* 0. Inputs are ignored during any reset cycle, including reset asserted mid-operation; outstanding locks are discarded.
- Per-cycle update for each index i:
  - L = number of channels with lock_idx_en and lock_idx == i; U = same for unlocks.
  - next = cnt + L - U, computed signed at CNT_W+$clog2(N_LOCK_CHANNELS)+2 bits.
  - next < 0: counter := 0, err_underflow := 1.
  - next > MAX_LOCKS_PER_IDX: counter := MAX, err_overflow := 1.
  - Otherwise counter := next.
  - Net arithmetic governs errors. A lock and an unlock of the same zero-count index in the same cycle yields 0 with no error. Two channels locking the same index in one cycle add 2.
- Query latency 1 cycle:
  - query_valid[q] and query_locked[q] at t+1 reflect the counter value after the updates applied at edge t. Updates issued in cycle t are forwarded to queries issued in cycle t.
  - query_locked is 0 whenever query_valid is 0.
- n_locked and idle are registered and reflect post-update state with the same 1-cycle latency. They are computed from next-state nonzero flags.
- err_* are sticky until reset; counters keep operating after an error.
- No backpressure: every strobe is consumed in its cycle.

Decomposition:
- Shared package cci_mpf_shim_pwrite_pkg holds:
  - function for packed-slice extraction of an index from a flattened port;
  - localparam helpers for CNT_W / IDX_W derivation;
  - t_pwrite_lock_err enum {NONE, OVERFLOW, UNDERFLOW}.
- Index typedefs stay parameter-local, matching the existing interfaces.
- One sub-module: cci_mpf_shim_pwrite_lock_cnt, a single saturating up/down counter.
  - Inputs: n_inc, n_dec, reset.
  - Outputs: count, nonzero_next, ovf, udf.
  - The top instantiates N_WRITE_HEAP_ENTRIES copies, decodes the channel strobes, and ORs the errors.

Test Plan:
1. Reset, then query idx 5 on port 0 -> query_valid[0]=1, query_locked[0]=0, idle=1, n_locked=0.
2. Lock idx 7 on ch0 at t, query idx 7 at t -> query_locked=1 at t+1, n_locked=1. Unlock idx 7 at t+3, query at t+3 -> query_locked=0 at t+4, idle=1.
3. ch0 and ch1 both lock idx 3 in one cycle, then one unlock -> idx 3 still locked (count 1). Second unlock -> unlocked. No err_* asserted.
4. Lock idx 9 four times with MAX_LOCKS_PER_IDX=3 -> err_overflow=1, count stays 3. Three unlocks -> unlocked. A fourth unlock -> err_underflow=1, count 0.
5. Same-cycle lock and unlock of zero-count idx 12 -> count 0, query_locked=0, no error flags.
6. Lock idx 0, 63 and 127; assert reset for 1 cycle with concurrent lock of idx 1 -> after reset all queries return 0, n_locked=0, err_* cleared, idx 1 not locked.
